reply_scheduler: RTL and testbench

REPLY_SCHEDULER -- requirements
Module: reply_scheduler

---
 rtl/reply_scheduler_if.sv | 26 ++
 rtl/reply_scheduler.sv | 136 +++++++++++++
 tb/tb_reply_scheduler.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reply_scheduler_if.sv
// reply_scheduler_if: receiver/transmitter handshake bundle for reply_scheduler.
// The master modport drives the frame and transmitter status; the slave is the scheduler.
interface reply_scheduler_if;
  localparam int unsigned CMD_W = 3;

  logic             rx_frame_end;
  logic             rx_err;
  logic [CMD_W-1:0] cmd_type;
  logic             tx_busy;
  logic             tx_frame_end;
  logic             tx_start;
  logic [CMD_W-1:0] reply_type;
  logic             reply_pending;
  logic             deadline_miss;
  logic             cmd_overrun;

  modport master (
    output rx_frame_end, rx_err, cmd_type, tx_busy, tx_frame_end,
    input  tx_start, reply_type, reply_pending, deadline_miss, cmd_overrun
  );

  modport slave (
    input  rx_frame_end, rx_err, cmd_type, tx_busy, tx_frame_end,
    output tx_start, reply_type, reply_pending, deadline_miss, cmd_overrun
  );
endinterface

// File: rtl/reply_scheduler.sv
// reply_scheduler: issues a reply tx_start exactly TURNAROUND cycles after a valid command
// frame end (or later if the transmitter is busy). Define REPLY_DEADLINE_EN to drop late replies.
module reply_scheduler #(
  parameter int unsigned TURNAROUND = 4,
  parameter int unsigned DEADLINE   = 16,
  parameter int unsigned CW         = 8
) (
  input  logic             clk,
  input  logic             rst,
  reply_scheduler_if.slave bus
);
  localparam int unsigned   TW      = 3;
  localparam logic [CW-1:0] TA_LAST = CW'(TURNAROUND - 1);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  if (TURNAROUND < 1 || DEADLINE <= TURNAROUND || (DEADLINE >> CW) != 0) begin : g_param_check
    $error("reply_scheduler: illegal TURNAROUND/DEADLINE/CW combination");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_TURN, ST_WAIT, ST_SEND} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [TW-1:0]   cmd_q, cmd_d, rtype_q, rtype_d;
  logic            fe_q, fe_d, err_q, err_d;
  logic            start_q, start_d, miss_q, miss_d, ovr_q, ovr_d, pend_q, pend_d;
  logic            tick, cmd_onehot, valid, accept, launch, at_deadline;

  assign tick       = ~bus.rx_frame_end & fe_q;
  assign cmd_onehot = (cmd_q == 3'b001) || (cmd_q == 3'b010) || (cmd_q == 3'b100);
  assign valid      = tick & ~err_q & cmd_onehot;

`ifdef REPLY_DEADLINE_EN
  localparam logic [CW-1:0] DL_LAST = CW'(DEADLINE - 1);
  assign at_deadline = (state_q == ST_WAIT) && !valid && (cnt_q == DL_LAST);
`else
  assign at_deadline = 1'b0;
`endif

  // Counter value equals cycles elapsed since the accepted tick (the tick cycle itself is 0),
  // so the send decision at TURNAROUND-1 registers tx_start exactly TURNAROUND cycles later.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rtype_d = rtype_q;
    start_d = 1'b0;
    miss_d  = 1'b0;
    ovr_d   = 1'b0;
    accept  = 1'b0;
    launch  = 1'b0;
    fe_d    = bus.rx_frame_end;
    cmd_d   = bus.rx_frame_end ? bus.cmd_type : cmd_q;
    err_d   = bus.rx_frame_end ? bus.rx_err : err_q;
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

    case (state_q)
      ST_IDLE: accept = valid;
      ST_TURN, ST_WAIT: begin
        if (valid) begin
          accept = 1'b1;
          ovr_d  = 1'b1;
        end else begin
          cnt_d  = cnt_inc;
          launch = (state_q == ST_WAIT) || (cnt_q == TA_LAST);
        end
      end
      ST_SEND: begin
        if (bus.tx_frame_end) begin
          accept = valid;
          if (!valid) begin
            state_d = ST_IDLE;
            rtype_d = '0;
          end
        end else begin
          ovr_d = valid;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      rtype_d = cmd_q;
      cnt_d   = CW'(1);
      state_d = ST_TURN;
      launch  = (TURNAROUND == 1);
    end

    // Ready to send: go now if the transmitter is free, else wait (or drop at the deadline).
    if (launch) begin
      if (!bus.tx_busy) begin
        start_d = 1'b1;
        state_d = ST_SEND;
      end else if (at_deadline) begin
        miss_d  = 1'b1;
        state_d = ST_IDLE;
        rtype_d = '0;
      end else begin
        state_d = ST_WAIT;
      end
    end

    pend_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
      rtype_q <= '0;
      fe_q    <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      miss_q  <= 1'b0;
      ovr_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      rtype_q <= rtype_d;
      fe_q    <= fe_d;
      err_q   <= err_d;
      start_q <= start_d;
      miss_q  <= miss_d;
      ovr_q   <= ovr_d;
      pend_q  <= pend_d;
    end
  end

  assign bus.tx_start      = start_q;
  assign bus.reply_type    = rtype_q;
  assign bus.reply_pending = pend_q;
  assign bus.deadline_miss = miss_q;
  assign bus.cmd_overrun   = ovr_q;
endmodule

// File: tb/tb_reply_scheduler.sv
// tb_reply_scheduler: directed scenarios plus random traffic, compared every cycle against an
// age-based behavioural model of the reply rules (deadline rules follow REPLY_DEADLINE_EN).
module tb_reply_scheduler;
  localparam int unsigned TURNAROUND = 4;
  localparam int unsigned DEADLINE   = 16;
  localparam int unsigned CW         = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  reply_scheduler_if bus ();

  reply_scheduler #(.TURNAROUND(TURNAROUND), .DEADLINE(DEADLINE), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // stimulus values applied each cycle
  logic       fe_v = 1'b0, er_v = 1'b0, busy_v = 1'b0, tfe_v = 1'b0;
  logic [2:0] ct_v = 3'b000;

  int n_checks = 0;
  int n_pass   = 0;
  int ncyc     = 0;
  int starts   = 0;

  // reference model: pending reply tracked by the cycle of its accepted tick
  bit         m_fe, m_err, m_active, m_sending;
  logic [2:0] m_cmd, m_type;
  int         m_tick;
  bit         e_start, e_miss, e_ovr;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", tag, got, exp, ncyc, $time);
  endtask

  task automatic model_reset();
    m_fe = 0; m_err = 0; m_active = 0; m_sending = 0;
    m_cmd = '0; m_type = '0; m_tick = 0;
    e_start = 0; e_miss = 0; e_ovr = 0;
  endtask

  task automatic model_accept();
    m_active = 1;
    m_tick   = ncyc;
    m_type   = m_cmd;
  endtask

  task automatic model_step();
    bit tick, valid;
    int age;
    e_start = 0; e_miss = 0; e_ovr = 0;
    tick  = m_fe && !fe_v;
    valid = tick && !m_err && ($countones(m_cmd) == 1);
    if (m_sending) begin
      if (tfe_v) begin
        m_sending = 0;
        m_type    = '0;
        if (valid) model_accept();
      end else if (valid) begin
        e_ovr = 1;
      end
    end else if (valid) begin
      if (m_active) e_ovr = 1;
      model_accept();
    end
    age = ncyc - m_tick;
    if (m_active && age >= int'(TURNAROUND) - 1) begin
      if (!busy_v) begin
        e_start = 1; m_active = 0; m_sending = 1;
      end
`ifdef REPLY_DEADLINE_EN
      else if (age == int'(DEADLINE) - 1) begin
        e_miss = 1; m_active = 0; m_type = '0;
      end
`endif
    end
    m_fe = fe_v;
    if (fe_v) begin
      m_cmd = ct_v;
      m_err = er_v;
    end
  endtask

  // apply inputs for one cycle, advance the model at the edge, compare on the falling edge
  task automatic step();
    bus.rx_frame_end = fe_v;
    bus.cmd_type     = ct_v;
    bus.rx_err       = er_v;
    bus.tx_busy      = busy_v;
    bus.tx_frame_end = tfe_v;
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    @(negedge clk);
    check("tx_start",      int'(bus.tx_start),      int'(e_start));
    check("deadline_miss", int'(bus.deadline_miss), int'(e_miss));
    check("cmd_overrun",   int'(bus.cmd_overrun),   int'(e_ovr));
    check("reply_type",    int'(bus.reply_type),    int'(m_type));
    check("reply_pending", int'(bus.reply_pending), int'(m_active || m_sending));
    if (bus.tx_start) starts++;
    ncyc++;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  // one cycle of frame, then the tick cycle; returns with tick+1 outputs visible
  task automatic send_cmd(input logic [2:0] ct, input logic er);
    fe_v = 1'b1; ct_v = ct; er_v = er;
    step();
    fe_v = 1'b0; ct_v = 3'($urandom); er_v = 1'($urandom);
    step();
  endtask

  task automatic tx_done();
    tfe_v = 1'b1;
    step();
    tfe_v = 1'b0;
  endtask

  // steps until the chosen pulse is seen; lat counts cycles since the tick
  task automatic wait_pulse(input bit want_miss, input int start_lat, output int lat);
    lat = start_lat;
    while (lat < 64 && !(want_miss ? bus.deadline_miss : bus.tx_start)) begin
      step();
      lat++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, s0, r;
    model_reset();
    idle(3);
    check("rst_pending", int'(bus.reply_pending), 0);
    rst = 1'b0;
    idle(4);

    // nominal SR command
    send_cmd(3'b001, 1'b0);
    check("nom_type", int'(bus.reply_type), 1);
    wait_pulse(1'b0, 1, lat);
    check("nom_latency", lat, int'(TURNAROUND));
    idle(12);
    tx_done();
    check("nom_done_type", int'(bus.reply_type), 0);

    // error / encoding filter
    send_cmd(3'b001, 1'b1); idle(8);
    send_cmd(3'b011, 1'b0); idle(8);
    send_cmd(3'b000, 1'b0); idle(8);
    check("filt_pending", int'(bus.reply_pending), 0);

    // busy transmitter through tick+8
    busy_v = 1'b1;
    send_cmd(3'b100, 1'b0);
    idle(8);
    busy_v = 1'b0;
    wait_pulse(1'b0, 9, lat);
    check("busy_latency", lat, 10);
    idle(5);
    tx_done();

    // transmitter held busy past the deadline
    busy_v = 1'b1;
    send_cmd(3'b001, 1'b0);
`ifdef REPLY_DEADLINE_EN
    wait_pulse(1'b1, 1, lat);
    check("dl_latency", lat, int'(DEADLINE));
    check("dl_pending", int'(bus.reply_pending), 0);
    busy_v = 1'b0;
    idle(10);
`else
    idle(23);
    busy_v = 1'b0;
    wait_pulse(1'b0, 24, lat);
    check("nodl_latency", lat, 25);
    idle(3);
    tx_done();
`endif

    // overrun: CCW then DPR two cycles later
    send_cmd(3'b100, 1'b0);
    fe_v = 1'b1; ct_v = 3'b010; er_v = 1'b0;
    step();
    fe_v = 1'b0;
    step();
    check("ovr_pulse", int'(bus.cmd_overrun), 1);
    check("ovr_type", int'(bus.reply_type), 2);
    wait_pulse(1'b0, 1, lat);
    check("ovr_latency", lat, int'(TURNAROUND));
    send_cmd(3'b001, 1'b0);
    check("send_ovr_pulse", int'(bus.cmd_overrun), 1);
    check("send_ovr_type", int'(bus.reply_type), 2);
    idle(3);
    // new command lands on the same cycle the reply finishes
    fe_v = 1'b1; ct_v = 3'b001; er_v = 1'b0;
    step();
    fe_v = 1'b0; tfe_v = 1'b1;
    step();
    tfe_v = 1'b0;
    check("swap_ovr", int'(bus.cmd_overrun), 0);
    check("swap_type", int'(bus.reply_type), 1);
    wait_pulse(1'b0, 1, lat);
    check("swap_latency", lat, int'(TURNAROUND));
    idle(2);
    tx_done();

    // asynchronous reset while waiting for the transmitter
    busy_v = 1'b1;
    send_cmd(3'b010, 1'b0);
    idle(6);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("rst_async_pending", int'(bus.reply_pending), 0);
    check("rst_async_type",    int'(bus.reply_type), 0);
    check("rst_async_start",   int'(bus.tx_start), 0);
    check("rst_async_miss",    int'(bus.deadline_miss), 0);
    check("rst_async_ovr",     int'(bus.cmd_overrun), 0);
    busy_v = 1'b0;
    idle(2);
    rst = 1'b0;
    s0 = starts;
    idle(20);
    check("rst_no_start", starts - s0, 0);
    send_cmd(3'b001, 1'b0);
    wait_pulse(1'b0, 1, lat);
    check("rst_new_latency", lat, int'(TURNAROUND));
    tx_done();

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      if (fe_v) begin
        if ($urandom_range(0, 2) == 0) fe_v = 1'b0;
      end else if ($urandom_range(0, 7) == 0) begin
        fe_v = 1'b1;
      end
      r    = int'($urandom_range(0, 9));
      ct_v = (r < 7) ? 3'(1 << (r % 3)) : 3'($urandom);
      er_v = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 11) == 0) busy_v = ~busy_v;
      tfe_v = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
